// File: rtl/riscv_pkg.sv
// Shared constants for the register scoreboard: register-index width, register
// count, pending-write counter width and stall-counter width.
package riscv_pkg;
  localparam int ADDRESS_WIDTH   = 5;
  localparam int REG_COUNT       = 2 ** ADDRESS_WIDTH;
  localparam int CNT_WIDTH       = 2;
  localparam int STALL_CNT_WIDTH = 16;
endpackage

// File: rtl/sb_counter.sv
// One pending-write counter. It saturates at both ends, holds when inc and dec
// arrive together, and clears on clr_i. The caller gates inc/dec against full/empty.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         nonzero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign full_o    = (cnt_q == '1);
  assign nonzero_o = (cnt_q != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register and blocks issue on
// RAW hazards or a full counter. It allows same-cycle writeback bypass.
module reg_scoreboard #(
  parameter int ADDRESS_WIDTH = riscv_pkg::ADDRESS_WIDTH,
  parameter int CNT_WIDTH     = riscv_pkg::CNT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  issue_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]              issue_rs1_i,
  input  logic [ADDRESS_WIDTH-1:0]              issue_rs2_i,
  input  logic                                  issue_rs1_used_i,
  input  logic                                  issue_rs2_used_i,
  input  logic [ADDRESS_WIDTH-1:0]              issue_rd_i,
  input  logic                                  issue_rd_we_i,
  output logic                                  issue_ready_o,
  input  logic                                  wb_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]              wb_rd_i,
  input  logic                                  flush_i,
  output logic [2**ADDRESS_WIDTH-1:0]           busy_o,
  output logic [riscv_pkg::STALL_CNT_WIDTH-1:0] stall_cnt_o,
  output logic                                  err_o
);
  import riscv_pkg::*;

  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

  logic [CNT_WIDTH-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0]        cnt_full, cnt_nz, inc, dec;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                       err_q, err_d;
  logic                       rs1_wb, rs2_wb, rd_wb;
  logic                       rs1_haz, rs2_haz, rd_full, fire;

  assign cnt[0]      = '0;
  assign cnt_full[0] = 1'b0;
  assign cnt_nz[0]   = 1'b0;
  assign inc[0]      = 1'b0;
  assign dec[0]      = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    assign inc[i] = fire && issue_rd_we_i && (issue_rd_i == ADDRESS_WIDTH'(i));
    assign dec[i] = wb_valid_i && (wb_rd_i == ADDRESS_WIDTH'(i)) && cnt_nz[i];
    sb_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (flush_i),
      .inc_i    (inc[i]),
      .dec_i    (dec[i]),
      .cnt_o    (cnt[i]),
      .full_o   (cnt_full[i]),
      .nonzero_o(cnt_nz[i])
    );
  end

  // A same-cycle writeback lands before the read, so it removes one pending write.
  assign rs1_wb  = wb_valid_i && (wb_rd_i == issue_rs1_i);
  assign rs2_wb  = wb_valid_i && (wb_rd_i == issue_rs2_i);
  assign rd_wb   = wb_valid_i && (wb_rd_i == issue_rd_i);
  assign rs1_haz = issue_rs1_used_i && (cnt[issue_rs1_i] > CNT_WIDTH'(rs1_wb));
  assign rs2_haz = issue_rs2_used_i && (cnt[issue_rs2_i] > CNT_WIDTH'(rs2_wb));
  assign rd_full = issue_rd_we_i && (issue_rd_i != '0) && cnt_full[issue_rd_i] && !rd_wb;

  assign issue_ready_o = !(rs1_haz || rs2_haz || rd_full);
  assign fire          = issue_valid_i && issue_ready_o;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    if (issue_valid_i && !issue_ready_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
    if (wb_valid_i && (wb_rd_i != '0) && !cnt_nz[wb_rd_i]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = cnt_nz;
  assign stall_cnt_o = stall_cnt_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard. The stimulus pushes hand-computed
// expectations per cycle, and a monitor pops and compares them at the falling edge.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i, issue_rs1_used_i, issue_rs2_used_i, issue_rd_we_i;
  logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i, wb_rd_i;
  logic        wb_valid_i, flush_i;
  logic        issue_ready_o, err_o;
  logic [31:0] busy_o;
  logic [15:0] stall_cnt_o;

  typedef struct {
    string       name;
    logic        rdy;
    logic [31:0] busy;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid_i),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_rs1_used_i(issue_rs1_used_i),
    .issue_rs2_used_i(issue_rs2_used_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rd_we_i   (issue_rd_we_i),
    .issue_ready_o   (issue_ready_o),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_i         (wb_rd_i),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .stall_cnt_o     (stall_cnt_o),
    .err_o           (err_o)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.name, ".ready"}, 32'(issue_ready_o), 32'(e.rdy));
        cmp({e.name, ".busy"},  busy_o,             e.busy);
        cmp({e.name, ".stall"}, 32'(stall_cnt_o),   32'(e.stall));
        cmp({e.name, ".err"},   32'(err_o),         32'(e.err));
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic we, input logic wbv, input logic [4:0] wbrd,
                     input logic fl, input logic r);
    issue_valid_i    = v;
    issue_rs1_i      = rs1;
    issue_rs1_used_i = u1;
    issue_rs2_i      = rs2;
    issue_rs2_used_i = u2;
    issue_rd_i       = rd;
    issue_rd_we_i    = we;
    wb_valid_i       = wbv;
    wb_rd_i          = wbrd;
    flush_i          = fl;
    rst              = r;
  endtask

  task automatic expect_state(input string n, input logic rdy, input logic [31:0] b,
                              input logic [15:0] s, input logic e);
    exp_t x;
    x.name = n; x.rdy = rdy; x.busy = b; x.stall = s; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    //   v  rs1 u1 rs2 u2 rd  we wbv wbrd fl rst
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);              tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_state("reset", 1, 32'h0, 16'd0, 0);          tick();

    // RAW hazard on r5 and its bypass
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    expect_state("wr5", 1, 32'h0, 16'd0, 0);            tick();
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("raw5_a", 0, 32'h20, 16'd0, 0);        tick();
    expect_state("raw5_b", 0, 32'h20, 16'd1, 0);        tick();
    drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    expect_state("bypass5", 1, 32'h20, 16'd2, 0);       tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("clear5", 1, 32'h0, 16'd2, 0);         tick();

    // counter full on r7
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    expect_state("wr7_1", 1, 32'h0, 16'd2, 0);          tick();
    expect_state("wr7_2", 1, 32'h80, 16'd2, 0);         tick();
    expect_state("wr7_3", 1, 32'h80, 16'd2, 0);         tick();
    expect_state("full7", 0, 32'h80, 16'd2, 0);         tick();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    expect_state("full7_wb", 1, 32'h80, 16'd3, 0);      tick();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    expect_state("still_full7", 0, 32'h80, 16'd3, 0);   tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    expect_state("drain7_a", 1, 32'h80, 16'd4, 0);      tick();
    expect_state("drain7_b", 1, 32'h80, 16'd4, 0);      tick();
    expect_state("drain7_c", 1, 32'h80, 16'd4, 0);      tick();

    // index 0 never hazards
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    expect_state("wr0", 1, 32'h0, 16'd4, 0);            tick();
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    expect_state("rd0", 1, 32'h0, 16'd4, 0);            tick();

    // rs2 hazard, unused source ignored
    drv(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
    expect_state("wr12", 1, 32'h0, 16'd4, 0);           tick();
    drv(1, 3, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    expect_state("raw12_rs2", 0, 32'h1000, 16'd4, 0);   tick();
    drv(1, 3, 1, 12, 0, 0, 0, 0, 0, 0, 0);
    expect_state("unused12", 1, 32'h1000, 16'd5, 0);    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    expect_state("wb12", 1, 32'h1000, 16'd5, 0);        tick();

    // spurious writeback, flush, reset
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    expect_state("wb9_spur", 1, 32'h0, 16'd5, 0);       tick();
    drv(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0);
    expect_state("err_sticky", 1, 32'h0, 16'd5, 1);     tick();
    drv(1, 0, 0, 0, 0, 21, 1, 0, 0, 1, 0);
    expect_state("flush", 1, 32'h100000, 16'd5, 1);     tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("post_flush", 1, 32'h0, 16'd5, 1);     tick();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
    expect_state("rst_fire3", 1, 32'h0, 16'd5, 1);      tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("post_rst", 1, 32'h0, 16'd0, 0);       tick();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 5, giving the register-index width (2**ADDRESS_WIDTH registers).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 2, giving the width of each register's pending-write counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port issue_valid_i, input, 1 bit: the decode stage presents an instruction.
REQ-006 The block SHALL have ports issue_rs1_i and issue_rs2_i, input, ADDRESS_WIDTH bits each: the source indices driven to the register-file read ports.
REQ-007 The block SHALL have ports issue_rs1_used_i and issue_rs2_used_i, input, 1 bit each: the corresponding source is actually read.
REQ-008 The block SHALL have port issue_rd_i, input, ADDRESS_WIDTH bits: the destination index.
REQ-009 The block SHALL have port issue_rd_we_i, input, 1 bit: the instruction writes rd.
REQ-010 The block SHALL have port issue_ready_o, output, 1 bit: no hazard, so the instruction may issue.
REQ-011 The block SHALL have ports wb_valid_i, input, 1 bit, and wb_rd_i, input, ADDRESS_WIDTH bits: a writeback into the register file this cycle (the same event as the register-file write enable and write address).
REQ-012 The block SHALL have port flush_i, input, 1 bit: clear all pending state.
REQ-013 The block SHALL have port busy_o, output, 2**ADDRESS_WIDTH bits: bit i is set when register i has at least one pending write.
REQ-014 The block SHALL have port stall_cnt_o, output, 16 bits: saturating count of stall cycles.
REQ-015 The block SHALL have port err_o, output, 1 bit: sticky flag for a writeback with no pending write.

Function
REQ-016 Per register i (i != 0), the block SHALL keep a counter cnt[i] of issued-but-not-written-back writes; cnt[0] SHALL always be 0.
REQ-017 An issue fire SHALL be defined as issue_valid_i && issue_ready_o, where issue_ready_o is combinational.
REQ-018 On a fire with issue_rd_we_i = 1 and issue_rd_i != 0, cnt[issue_rd_i] SHALL increment at the next rising edge.
REQ-019 When wb_valid_i = 1, wb_rd_i != 0 and cnt[wb_rd_i] > 0, cnt[wb_rd_i] SHALL decrement at the next rising edge.
REQ-020 If an increment and a decrement hit the same register in one cycle, that counter SHALL stay unchanged.
REQ-021 Writeback bypass: a source SHALL count as hazarded only if cnt[rs] minus (wb_valid_i && wb_rd_i == rs ? 1 : 0) is greater than 0. This matches the register file's write-in-first-half, read-in-second-half timing.
REQ-022 issue_ready_o SHALL be 0 when any of the following holds, and 1 otherwise:
- a used source (rs1 or rs2) is hazarded;
- issue_rd_we_i = 1, issue_rd_i != 0, and cnt[issue_rd_i] equals 2**CNT_WIDTH-1 with no same-cycle writeback decrement to that register (counter full).
REQ-023 Index 0 SHALL never cause a hazard, whether as a source or as a destination.
REQ-024 busy_o[i] SHALL equal (cnt[i] != 0) as registered state, without the bypass.
REQ-025 A writeback with wb_rd_i != 0 and cnt[wb_rd_i] = 0 SHALL leave cnt unchanged and set err_o, which stays 1 until rst.
REQ-026 stall_cnt_o SHALL increment each cycle with issue_valid_i && !issue_ready_o and saturate at 0xFFFF.
REQ-027 flush_i SHALL set every cnt to 0 at the next edge and SHALL take priority over a same-cycle issue or writeback.
REQ-028 Writebacks of flushed instructions SHALL arrive with wb_valid_i = 0; this is guaranteed by the pipeline, not checked by this block.
REQ-029 flush_i SHALL NOT clear stall_cnt_o or err_o.

Reset
REQ-030 On a rising edge with rst = 1, every cnt, stall_cnt_o and err_o SHALL become 0, so busy_o = 0.
REQ-031 rst SHALL override flush_i, issue and writeback in the same cycle.
REQ-032 During reset, issue_ready_o SHALL stay combinational from the cleared state: 1 for any input with no same-cycle wb effect.

Structure
REQ-033 Shared package riscv_pkg SHALL hold ADDRESS_WIDTH, REG_COUNT = 2**ADDRESS_WIDTH, CNT_WIDTH and the stall-counter width constant.
REQ-034 A sub-module sb_counter SHALL implement one saturating up/down counter with inc, dec, clr and cnt/full/nonzero outputs. It SHALL be instantiated for indices 1..REG_COUNT-1, with index 0 tied to 0.

Verification
REQ-035 Scenario: issue rd=5 with we=1; next cycle issue rs1=5, used=1, no wb -> issue_ready_o = 0, busy_o[5] = 1, stall_cnt_o counts 1 per cycle.
REQ-036 Scenario: same state, then wb_valid_i = 1, wb_rd_i = 5 in the stalled cycle -> issue_ready_o = 1 in that same cycle; after the edge, cnt[5] = 0 if no new write was issued.
REQ-037 Scenario: issue three writes to rd=7 -> the third is accepted; a fourth write to 7 gives issue_ready_o = 0 (cnt = 3, full) until one wb to 7 occurs.
REQ-038 Scenario: issue rd=0 with we=1, then rs1=0 used -> busy_o = 0, issue_ready_o = 1 throughout.
REQ-039 Scenario: wb_rd_i = 9 with cnt[9] = 0 -> err_o = 1 and held; cnt unchanged. A subsequent flush_i = 1 -> busy_o = 0 and err_o still 1; rst -> err_o = 0.
REQ-040 Scenario: rst = 1 together with a fire to rd=3 -> next cycle busy_o = 0 and stall_cnt_o = 0.
